accum_scheduler: RTL and testbench
==================================

ACCUM_SCHEDULER -- requirements
Module: accum_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of signed input terms.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of per-job term count.
REQ-004 SHALL have parameter ACC_WIDTH, default DATA_WIDTH+CNT_WIDTH, signed result width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester job request, held until result or abort.
REQ-008 SHALL have port len  input  NUM_REQ*CNT_WIDTH  per-requester term count, slice i for requester i.
REQ-009 SHALL have port in_valid  input  NUM_REQ  per-requester term valid.
REQ-010 SHALL have port in_data  input  NUM_REQ*DATA_WIDTH  per-requester signed term.
REQ-011 SHALL have port in_ready  output  NUM_REQ  one-hot term accept, only to granted requester.
REQ-012 SHALL have port grant  output  NUM_REQ  one-hot owner of accumulator; zero when idle.
REQ-013 SHALL have port result  output  ACC_WIDTH  signed accumulated sum.
REQ-014 SHALL have port result_valid  output  1  one-cycle pulse qualifying result/result_id.
REQ-015 SHALL have port result_id  output  $clog2(NUM_REQ)  index of requester owning result.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 IDLE: if any req set, SHALL pick round-robin winner starting at index after last winner (index 0 first after reset), assert grant next cycle, latch len as remaining, clear sum, enter BUSY.
REQ-018 IDLE with winner's len==0 SHALL skip BUSY, enter DONE with result 0.
REQ-019 BUSY: in_ready SHALL be set for granted index only; a term transfers when in_valid & in_ready.
REQ-020 Each transfer SHALL add sign-extended in_data to sum and decrement remaining; no transfer, no change.
REQ-021 Transfer with remaining==1 SHALL enter DONE next cycle; in_ready SHALL drop in that same next cycle.
REQ-022 DONE: result_valid SHALL be 1 for exactly one cycle with result=sum, result_id=winner; grant cleared; next state IDLE.
REQ-023 Minimum job occupancy SHALL be len+2 cycles; one IDLE cycle SHALL separate consecutive jobs.
REQ-024 Winner deasserting req in BUSY SHALL abort: return to IDLE next cycle, no result_valid, pointer still advanced.
REQ-025 Requests from non-granted requesters SHALL be ignored until IDLE; in_valid from them SHALL never be accepted.
REQ-026 len, in_data of non-granted requesters SHALL not affect state; len changes after grant SHALL be ignored.
REQ-027 Without saturation, addition SHALL wrap modulo 2^ACC_WIDTH (two's complement).
REQ-028 result SHALL hold last value between pulses.

Reset
REQ-029 rstn low at a clock edge SHALL force IDLE, grant=0, in_ready=0, result_valid=0, result=0, result_id=0, sum=0, remaining=0, pointer=0, including mid-job; in-flight job discarded.

Configuration
REQ-030 Macro ACCUM_SCHEDULER_SAT_EN defined: each addition SHALL clamp to max/min signed ACC_WIDTH value instead of wrapping.
REQ-031 Macro undefined: wrapping per REQ-027; no saturation logic present.

Structure
REQ-032 Shared package accum_pkg SHALL hold state enum (IDLE/BUSY/DONE) and default-width localparams.
REQ-033 Datapath (sum register, sign-extension, wrap/saturate add, clear) SHALL be sub-module accum_datapath; FSM, arbiter, counter in top.

Verification
REQ-034 Single job: req[0]=1, len0=3, terms 2,-1,5 -> result=6, result_id=0, result_valid one cycle, 5 cycles after grant begins.
REQ-035 Contention: req=4'b1111 after reset, len=1 each -> result_id order 0,1,2,3; next round restarts at 0.
REQ-036 Zero length: req[2]=1, len2=0 -> result=0, result_id=2, in_ready never set.
REQ-037 Backpressure/abort: req[1], len=4, in_valid gaps -> only valid cycles counted; req[1] dropped after 2 terms -> no result_valid, next arbitration from index 2.
REQ-038 Overflow (DATA_WIDTH=4, ACC_WIDTH=5): 3 terms of 7 -> result -11 without macro, +15 with ACCUM_SCHEDULER_SAT_EN.
REQ-039 Mid-job reset: rstn low during BUSY -> all outputs zero next cycle, no result_valid after release.

Source files
------------

// File: rtl/accum_pkg.sv
// +----------------------------------------------------------------------+
// | accum_pkg : shared state encoding and default widths                 |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int C_DATA_WIDTH = 4;
  localparam int C_NUM_REQ    = 4;
  localparam int C_CNT_WIDTH  = 8;
  localparam int C_ACC_WIDTH  = C_DATA_WIDTH + C_CNT_WIDTH;

endpackage

`default_nettype wire

// File: rtl/accum_datapath.sv
// +----------------------------------------------------------------------+
// | accum_datapath : signed sum register with clear, wrap/saturate add   |
// | and a held result register. Saturation: ACCUM_SCHEDULER_SAT_EN.      |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module accum_datapath
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int ACC_WIDTH  = C_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr_i,
  input  logic                  add_i,
  input  logic [DATA_WIDTH-1:0] term_i,
  input  logic                  load_i,
  output logic [ACC_WIDTH-1:0]  result_o
);

  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_add;

`ifdef ACCUM_SCHEDULER_SAT_EN
  localparam logic [ACC_WIDTH-1:0] C_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] C_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] w_wide;
`endif

  always_comb begin
    w_ext = ACC_WIDTH'($signed(term_i));
`ifdef ACCUM_SCHEDULER_SAT_EN
    // One guard bit: differing top two bits means the signed add overflowed.
    w_wide = {sum_q[ACC_WIDTH-1], sum_q} + {w_ext[ACC_WIDTH-1], w_ext};
    if (w_wide[ACC_WIDTH] != w_wide[ACC_WIDTH-1]) begin
      w_add = w_wide[ACC_WIDTH] ? C_MIN : C_MAX;
    end else begin
      w_add = w_wide[ACC_WIDTH-1:0];
    end
`else
    w_add = sum_q + w_ext;
`endif
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = w_add;
    end
    result_d = load_i ? sum_d : result_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sum_q    <= '0;
      result_q <= '0;
    end else begin
      sum_q    <= sum_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

`default_nettype wire

// File: rtl/accum_scheduler.sv
// +----------------------------------------------------------------------+
// | accum_scheduler : round-robin arbiter sharing one accumulator among  |
// | NUM_REQ requesters. Optional saturation: ACCUM_SCHEDULER_SAT_EN.     |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module accum_scheduler
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int NUM_REQ    = C_NUM_REQ,
  parameter int CNT_WIDTH  = C_CNT_WIDTH,
  parameter int ACC_WIDTH  = DATA_WIDTH + CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]    len,
  input  logic [NUM_REQ-1:0]              in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   in_data,
  output logic [NUM_REQ-1:0]              in_ready,
  output logic [NUM_REQ-1:0]              grant,
  output logic [ACC_WIDTH-1:0]            result,
  output logic                            result_valid,
  output logic [$clog2(NUM_REQ)-1:0]      result_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;

  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [IDX_W-1:0]     w_cand;
  int                   w_scan;
  logic [CNT_WIDTH-1:0] w_len;
  logic [DATA_WIDTH-1:0] w_term;
  logic [NUM_REQ-1:0]   w_onehot;
  logic                 w_xfer;
  logic                 w_clr;
  logic                 w_load;

  // Scan starts at the slot after the previous winner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = 0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan = int'(ptr_q) + i;
      if (w_scan >= NUM_REQ) begin
        w_scan = w_scan - NUM_REQ;
      end
      w_cand = w_scan[IDX_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_len  = len[int'(w_pick)*CNT_WIDTH +: CNT_WIDTH];
  assign w_term = in_data[int'(winner_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    w_onehot           = '0;
    w_onehot[winner_q] = 1'b1;
    state_d            = state_q;
    winner_d           = winner_q;
    ptr_d              = ptr_q;
    rem_d              = rem_q;
    w_clr              = 1'b0;
    w_load             = 1'b0;
    grant              = '0;
    in_ready           = '0;
    result_valid       = 1'b0;

    // A dropped request in BUSY gates off in_ready so the abort cycle moves no data.
    if (state_q == BUSY) begin
      grant = w_onehot;
      if (req[winner_q]) begin
        in_ready = w_onehot;
      end
    end
    w_xfer = |(in_valid & in_ready);

    case (state_q)
      IDLE: begin
        if (w_found) begin
          winner_d = w_pick;
          ptr_d    = (w_pick == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
          rem_d    = w_len;
          w_clr    = 1'b1;
          if (w_len == '0) begin
            w_load  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req[winner_q]) begin
          state_d = IDLE;
        end else if (w_xfer) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_WIDTH'(1)) begin
            w_load  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      winner_q <= '0;
      ptr_q    <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
    end
  end

  accum_datapath #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (w_clr),
    .add_i    (w_xfer),
    .term_i   (w_term),
    .load_i   (w_load),
    .result_o (result)
  );

  assign result_id = winner_q;

endmodule

`default_nettype wire

// File: tb/tb_accum_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_accum_scheduler : job-level model plus directed jobs for          |
// | accum_scheduler (DATA_WIDTH=4, ACC_WIDTH=5 so overflow is reachable) |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_accum_scheduler;

  localparam int DW = 4;
  localparam int NR = 4;
  localparam int CW = 8;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NR-1:0]   req;
  logic [NR*CW-1:0] len;
  logic [NR-1:0]   in_valid;
  logic [NR*DW-1:0] in_data;
  logic [NR-1:0]   in_ready;
  logic [NR-1:0]   grant;
  logic [AW-1:0]   result;
  logic            result_valid;
  logic [1:0]      result_id;

  always #5 clk = ~clk;

  accum_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .CNT_WIDTH  (CW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req          (req),
    .len          (len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .grant        (grant),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;
  int g0_cnt   = 0;
  int r2_cnt   = 0;
  int pq_id[$];
  int pq_res[$];
  int terms [0:7];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Job-level model: who owns the accumulator, terms left, running sum.
  int m_owner = -1;
  int m_left  = 0;
  int m_sum   = 0;
  int m_res   = 0;
  int m_id    = 0;
  int m_next  = 0;
  bit m_pulse = 1'b0;

  function automatic int fold(input int s);
`ifdef ACCUM_SCHEDULER_SAT_EN
    if (s > 15)  return 15;
    if (s < -16) return -16;
    return s;
`else
    return (((s + 16) % 32) + 32) % 32 - 16;
`endif
  endfunction

  function automatic int sdata(input int i);
    logic signed [DW-1:0] v;
    v = in_data[i*DW +: DW];
    return int'(v);
  endfunction

  always @(posedge clk) begin : model
    int w;
    bit hit;
    cyc++;
    if (!rstn) begin
      m_owner = -1; m_left = 0; m_sum = 0; m_pulse = 0;
      m_res = 0; m_id = 0; m_next = 0;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (m_owner < 0) begin
      hit = 0;
      for (int k = 0; k < NR; k++) begin
        if (!hit && req[(m_next + k) % NR]) begin
          hit = 1;
          w = (m_next + k) % NR;
        end
      end
      if (hit) begin
        m_next = (w + 1) % NR;
        if (len[w*CW +: CW] == 0) begin
          m_pulse = 1; m_res = 0; m_id = w;
        end else begin
          m_owner = w; m_left = int'(len[w*CW +: CW]); m_sum = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (in_valid[m_owner]) begin
      m_sum = fold(m_sum + sdata(m_owner));
      m_left--;
      if (m_left == 0) begin
        m_pulse = 1; m_res = m_sum; m_id = m_owner; m_owner = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int eg;
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      chk("grant", int'(grant), eg);
      chk("in_ready", int'(in_ready), (m_owner >= 0 && req[m_owner]) ? eg : 0);
      chk("result_valid", int'(result_valid), int'(m_pulse));
      chk("result", int'($signed(result)), m_res);
      if (m_pulse) chk("result_id", int'(result_id), m_id);
    end
  end

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      pq_id.push_back(int'(result_id));
      pq_res.push_back(int'($signed(result)));
    end
    if (grant[0] === 1'b1)    g0_cnt++;
    if (in_ready[2] === 1'b1) r2_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input int i, input int n, input logic [15:0] vmask);
    int k = 0;
    int t = 0;
    while (k < n && t < 64) begin
      in_valid[i]        = vmask[t % 16];
      in_data[i*DW +: DW] = 4'(terms[k]);
      @(negedge clk);
      if (in_valid[i] && in_ready[i]) k++;
      step();
      t++;
    end
    in_valid[i] = 1'b0;
    chk("terms_accepted", k, n);
  endtask

  task automatic wait_pulse(input int budget, output int r, output int id);
    bit got = 0;
    r = 0; id = -1;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        got = 1;
        r   = int'($signed(result));
        id  = int'(result_id);
      end
    end
    chk("pulse_seen", int'(got), 1);
  endtask

  task automatic quiet(input int cycles);
    int n0 = pq_id.size();
    repeat (cycles) step();
    chk("no_pulse", pq_id.size() - n0, 0);
  endtask

  task automatic reset_outputs_zero();
    @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_id", int'(result_id), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, limit 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, id, t0, pc;
    rstn = 1'b0; req = '0; len = '0; in_valid = '0; in_data = '0;
    step();
    chk_en = 1'b1;
    reset_outputs_zero();
    step();
    rstn = 1'b1;
    step();

    // Single job on requester 0: 2 + -1 + 5 = 6, pulse in 5th cycle of the job.
    terms[0] = 2; terms[1] = -1; terms[2] = 5;
    len[0*CW +: CW] = 3;
    g0_cnt = 0; t0 = cyc;
    req[0] = 1'b1;
    feed(0, 3, 16'hFFFF);
    wait_pulse(10, r, id);
    pc = cyc;
    step(); req[0] = 1'b0;
    chk("t1_result", r, 6);
    chk("t1_id", id, 0);
    chk("t1_latency", pc - t0, 4);
    chk("t1_grant_cycles", g0_cnt, 3);

    // Backpressure on requester 1: 3 - 2 + 1 + 4 = 6 with valid gaps.
    terms[0] = 3; terms[1] = -2; terms[2] = 1; terms[3] = 4;
    len[1*CW +: CW] = 4;
    req[1] = 1'b1;
    feed(1, 4, 16'b1010_0110_1101_0010);
    wait_pulse(10, r, id);
    step(); req[1] = 1'b0;
    chk("t2_result", r, 6);
    chk("t2_id", id, 1);

    // Overflow on requester 3: 7+7+7.
    terms[0] = 7; terms[1] = 7; terms[2] = 7;
    len[3*CW +: CW] = 3;
    req[3] = 1'b1;
    feed(3, 3, 16'hFFFF);
    wait_pulse(10, r, id);
    step(); req[3] = 1'b0;
`ifdef ACCUM_SCHEDULER_SAT_EN
    chk("t3_result", r, 15);
`else
    chk("t3_result", r, -11);
`endif
    chk("t3_id", id, 3);

    // Abort: requester 1 drops after 2 of 4 terms.
    terms[0] = 1; terms[1] = 1;
    len[1*CW +: CW] = 4;
    req[1] = 1'b1;
    feed(1, 2, 16'h5555);
    req[1] = 1'b0;
    quiet(6);

    // Pointer moved past 1 on the abort, so 2 wins over 0 and 1; zero length.
    len[0*CW +: CW] = 2; len[1*CW +: CW] = 2; len[2*CW +: CW] = 0;
    r2_cnt = 0;
    req = 4'b0111;
    wait_pulse(10, r, id);
    step(); req = '0;
    chk("t5_id", id, 2);
    chk("t5_result", r, 0);
    chk("t5_in_ready2_cycles", r2_cnt, 0);
    quiet(4);

    // Contention after reset: ids 0,1,2,3 then 0 again.
    rstn = 1'b0; step(); step(); rstn = 1'b1;
    for (int i = 0; i < NR; i++) begin
      len[i*CW +: CW]     = 1;
      in_data[i*DW +: DW] = 4'(i + 1);
    end
    in_valid = '1;
    pq_id.delete(); pq_res.delete();
    req = '1;
    for (int c = 0; c < 60 && pq_id.size() < 5; c++) @(negedge clk);
    step(); req = '0; in_valid = '0;
    chk("t6_count", (pq_id.size() >= 5) ? 1 : 0, 1);
    if (pq_id.size() >= 5) begin
      chk("t6_id0", pq_id[0], 0); chk("t6_id1", pq_id[1], 1);
      chk("t6_id2", pq_id[2], 2); chk("t6_id3", pq_id[3], 3);
      chk("t6_id4", pq_id[4], 0);
      chk("t6_res1", pq_res[1], 2); chk("t6_res3", pq_res[3], 4);
    end
    quiet(4);

    // Mid-job reset on requester 0.
    terms[0] = 1; terms[1] = 2;
    len[0*CW +: CW] = 5;
    req[0] = 1'b1;
    feed(0, 2, 16'hFFFF);
    rstn = 1'b0; req = '0;
    step();
    reset_outputs_zero();
    step(); rstn = 1'b1;
    quiet(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
